arm7tdmi_shift_seq: RTL and testbench
=====================================

ARM7TDMI_SHIFT_SEQ -- requirements
Module: arm7tdmi_shift_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  core clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 req_valid  in  1  shift operation offered by decode.
REQ-005 req_ready  out  1  high only in IDLE.
REQ-006 req_type  in  shift_type_t  LSL/LSR/ASR/ROR.
REQ-007 req_amount  in  5  immediate shift amount.
REQ-008 req_shift_reg  in  1  amount is taken from Rs[7:0].
REQ-009 req_rm, req_rs  in  4 each  operand and amount register numbers.
REQ-010 carry_in  in  1  CPSR C flag, sampled at acceptance.
REQ-011 pc_in  in  32  PC of the instruction, sampled at acceptance.
REQ-012 rf_raddr  out  4  register-file read address; read data is combinational.
REQ-013 rf_rdata  in  32  register-file read data.
REQ-014 flush  in  1  abort the in-flight operation.
REQ-015 res_valid / res_ready  out / in  1 each  result handshake.
REQ-016 res_data  out  32  shifted operand.
REQ-017 res_carry  out  1  shifter carry-out.

Function
REQ-018 States SHALL be IDLE, READ_RM, READ_RS, SHIFT and DONE.
REQ-019 IDLE SHALL accept when req_valid&&req_ready, go to READ_RM, and latch type, amount, shift_reg, rm, rs, carry_in and pc_in.
REQ-020 In READ_RM, rf_raddr=rm and rm_q SHALL capture rf_rdata; Rm==15 SHALL use pc+8 for immediate form and pc+12 for register form; next state is READ_RS if shift_reg, otherwise SHIFT.
REQ-021 In READ_RS, rf_raddr=rs and amt_q SHALL capture Rs[7:0]; Rs==15 SHALL use (pc+12)[7:0]; next state is SHIFT.
REQ-022 In SHIFT, result SHALL be registered into res_data/res_carry and the state SHALL go to DONE.
REQ-023 DONE SHALL hold res_valid high with stable data until res_ready; on the handshake edge the state SHALL go to IDLE, so there is no back-to-back accept.
REQ-024 Latency (acceptance edge to first res_valid cycle): immediate form 2 cycles, register form 3 cycles.
REQ-025 Immediate form SHALL pass type and amount to arm7tdmi_shifter unchanged; the shifter applies the LSR/ASR #0 = #32 and ROR #0 = RRX encodings.
REQ-026 Register form, amt_q==0: result=Rm and carry=carry_in for all types.
REQ-027 Register form, amt_q 1-31 (any type) and ROR with amt_q[4:0]!=0: drive the shifter with amt[4:0].
REQ-028 Register form, LSL: amt 32 gives 0 with C=Rm[0]; amt >32 gives 0 with C=0.
REQ-029 Register form, LSR: amt 32 gives 0 with C=Rm[31]; amt >32 gives 0 with C=0.
REQ-030 Register form, ASR: amt >=32 gives {32{Rm[31]}} with C=Rm[31].
REQ-031 Register form, ROR with amt!=0 and amt[4:0]==0: result=Rm, C=Rm[31].
REQ-032 flush SHALL take any state to IDLE next edge; no res_valid follows; flush takes priority over an IDLE accept in the same cycle.
REQ-033 rf_raddr SHALL be 0 outside READ_RM/READ_RS.

Reset
REQ-034 rst SHALL force IDLE, req_ready=1, res_valid=0, res_data=0, res_carry=0, rf_raddr=0, and clear all latches; mid-operation the operation is dropped.

Configuration
REQ-035 With ARM7TDMI_SHIFT_SEQ_PERF_EN defined, the block SHALL add perf_ops (16-bit, counts res handshakes) and perf_reg_ops (16-bit, counts register-form completions) outputs. Both saturate at 0xFFFF, are cleared by rst, and are not affected by flush.
REQ-036 Without ARM7TDMI_SHIFT_SEQ_PERF_EN, those ports and counters SHALL be absent.

Structure
REQ-037 shift_seq_state_t SHALL live in arm7tdmi_pkg beside the existing shift_type_t.
REQ-038 The block SHALL instantiate exactly one arm7tdmi_shifter sub-module; all special-case overrides stay in this block.

Verification
REQ-039 Rm=0x80000001, LSL #4 immediate: res_data 0x00000010, C=0, res_valid 2 cycles after accept.
REQ-040 Register-form LSR with Rm=0x80000001: Rs=0x20 gives 0/C=1; Rs=0x21 gives 0/C=0; Rs=0x100 (amt 0) with carry_in=1 gives 0x80000001/C=1.
REQ-041 Register-form ROR with Rm=0x80000001: Rs=0x20 gives 0x80000001/C=1; Rs=0x24 gives 0x18000000/C=0; ASR Rs=0x40 gives 0xFFFFFFFF/C=1.
REQ-042 Rm=15, pc=0x100: LSL R2 with R2=0 gives 0x10C; immediate LSL #0 gives 0x108.
REQ-043 Flush in READ_RS gives IDLE next cycle with no res_valid; rst asserted in SHIFT gives all outputs at reset values.
REQ-044 res_ready low for 5 cycles: res_data stable, req_ready=0, no new request accepted; perf_ops increments exactly once (PERF_EN build).

Source files
------------

// File: rtl/arm7tdmi_pkg.sv
// Shared ARM7TDMI types: barrel-shift operation codes and the shift sequencer state encoding.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'd0,
    SHIFT_LSR = 2'd1,
    SHIFT_ASR = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_type_t;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_READ_RM = 3'd1,
    SEQ_READ_RS = 3'd2,
    SEQ_SHIFT   = 3'd3,
    SEQ_DONE    = 3'd4
  } shift_seq_state_t;

  localparam logic [3:0] PC_REG_NUM = 4'd15;

endpackage

// File: rtl/arm7tdmi_shifter.sv
// Combinational ARM barrel shifter with immediate-form encodings (LSR/ASR #0 = #32, ROR #0 = RRX).
module arm7tdmi_shifter
  import arm7tdmi_pkg::*;
(
  input  shift_type_t  shift_type_i,
  input  logic [4:0]   amount_i,
  input  logic [31:0]  value_i,
  input  logic         carry_i,
  output logic [31:0]  result_o,
  output logic         carry_o
);

  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic [31:0] ror_w;

  always_comb begin
    // The extra bit catches the last bit shifted out, which is the carry.
    lsl_w = {1'b0, value_i} << amount_i;
    lsr_w = {value_i, 1'b0} >> amount_i;
    asr_w = 33'($signed({value_i, 1'b0}) >>> amount_i);
    ror_w = 32'({value_i, value_i} >> amount_i);

    result_o = value_i;
    carry_o  = carry_i;
    unique case (shift_type_i)
      SHIFT_LSL: begin
        if (amount_i != 5'd0) begin
          result_o = lsl_w[31:0];
          carry_o  = lsl_w[32];
        end
      end
      SHIFT_LSR: begin
        if (amount_i == 5'd0) begin
          result_o = 32'd0;
          carry_o  = value_i[31];
        end else begin
          result_o = lsr_w[32:1];
          carry_o  = lsr_w[0];
        end
      end
      SHIFT_ASR: begin
        if (amount_i == 5'd0) begin
          result_o = {32{value_i[31]}};
          carry_o  = value_i[31];
        end else begin
          result_o = asr_w[32:1];
          carry_o  = asr_w[0];
        end
      end
      SHIFT_ROR: begin
        if (amount_i == 5'd0) begin
          result_o = {carry_i, value_i[31:1]};
          carry_o  = value_i[0];
        end else begin
          result_o = ror_w;
          carry_o  = ror_w[31];
        end
      end
    endcase
  end

endmodule

// File: rtl/arm7tdmi_shift_seq.sv
// Multi-cycle shifter-operand sequencer: reads Rm (and Rs for register form), shifts, holds result.
// Optional perf counters are built when ARM7TDMI_SHIFT_SEQ_PERF_EN is defined.
module arm7tdmi_shift_seq
  import arm7tdmi_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  shift_type_t  req_type,
  input  logic [4:0]   req_amount,
  input  logic         req_shift_reg,
  input  logic [3:0]   req_rm,
  input  logic [3:0]   req_rs,
  input  logic         carry_in,
  input  logic [31:0]  pc_in,
  output logic [3:0]   rf_raddr,
  input  logic [31:0]  rf_rdata,
  input  logic         flush,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_data,
  output logic         res_carry
`ifdef ARM7TDMI_SHIFT_SEQ_PERF_EN
  ,
  output logic [15:0]  perf_ops,
  output logic [15:0]  perf_reg_ops
`endif
);

  shift_seq_state_t state_q;
  shift_type_t      type_q;
  logic [7:0]       amt_q;
  logic             shift_reg_q;
  logic [3:0]       rm_num_q;
  logic [3:0]       rs_num_q;
  logic             carry_q;
  logic [31:0]      pc_q;
  logic [31:0]      rm_q;
  logic             req_ready_q;
  logic             res_valid_q;
  logic [31:0]      res_data_q;
  logic             res_carry_q;
  logic [3:0]       rf_raddr_q;

  logic [31:0] pc12_d;
  logic [31:0] rm_val_d;
  logic [7:0]  rs_amt_d;
  logic [31:0] sh_result;
  logic        sh_carry;
  logic [31:0] shift_res_d;
  logic        shift_carry_d;

  // Reading R15 returns the pipelined PC: +8 normally, +12 when an extra Rs read cycle is spent.
  always_comb begin
    pc12_d   = pc_q + 32'd12;
    rm_val_d = (rm_num_q == PC_REG_NUM) ? (shift_reg_q ? pc12_d : pc_q + 32'd8) : rf_rdata;
    rs_amt_d = (rs_num_q == PC_REG_NUM) ? pc12_d[7:0] : rf_rdata[7:0];
  end

  arm7tdmi_shifter u_shifter (
    .shift_type_i (type_q),
    .amount_i     (amt_q[4:0]),
    .value_i      (rm_q),
    .carry_i      (carry_q),
    .result_o     (sh_result),
    .carry_o      (sh_carry)
  );

  // Register-form amounts of 0 or >=32 bypass the shifter's immediate encodings.
  always_comb begin
    shift_res_d   = sh_result;
    shift_carry_d = sh_carry;
    if (shift_reg_q) begin
      if (amt_q == 8'd0) begin
        shift_res_d   = rm_q;
        shift_carry_d = carry_q;
      end else if (amt_q >= 8'd32) begin
        unique case (type_q)
          SHIFT_LSL: begin
            shift_res_d   = 32'd0;
            shift_carry_d = (amt_q == 8'd32) ? rm_q[0] : 1'b0;
          end
          SHIFT_LSR: begin
            shift_res_d   = 32'd0;
            shift_carry_d = (amt_q == 8'd32) ? rm_q[31] : 1'b0;
          end
          SHIFT_ASR: begin
            shift_res_d   = {32{rm_q[31]}};
            shift_carry_d = rm_q[31];
          end
          SHIFT_ROR: begin
            if (amt_q[4:0] == 5'd0) begin
              shift_res_d   = rm_q;
              shift_carry_d = rm_q[31];
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      type_q      <= SHIFT_LSL;
      amt_q       <= 8'd0;
      shift_reg_q <= 1'b0;
      rm_num_q    <= 4'd0;
      rs_num_q    <= 4'd0;
      carry_q     <= 1'b0;
      pc_q        <= 32'd0;
      rm_q        <= 32'd0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'd0;
      res_carry_q <= 1'b0;
      rf_raddr_q  <= 4'd0;
    end else if (flush) begin
      state_q     <= SEQ_IDLE;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      rf_raddr_q  <= 4'd0;
    end else begin
      unique case (state_q)
        SEQ_IDLE: begin
          if (req_valid && req_ready_q) begin
            type_q      <= req_type;
            amt_q       <= {3'd0, req_amount};
            shift_reg_q <= req_shift_reg;
            rm_num_q    <= req_rm;
            rs_num_q    <= req_rs;
            carry_q     <= carry_in;
            pc_q        <= pc_in;
            req_ready_q <= 1'b0;
            rf_raddr_q  <= req_rm;
            state_q     <= SEQ_READ_RM;
          end
        end
        SEQ_READ_RM: begin
          rm_q <= rm_val_d;
          if (shift_reg_q) begin
            rf_raddr_q <= rs_num_q;
            state_q    <= SEQ_READ_RS;
          end else begin
            rf_raddr_q <= 4'd0;
            state_q    <= SEQ_SHIFT;
          end
        end
        SEQ_READ_RS: begin
          amt_q      <= rs_amt_d;
          rf_raddr_q <= 4'd0;
          state_q    <= SEQ_SHIFT;
        end
        SEQ_SHIFT: begin
          res_data_q  <= shift_res_d;
          res_carry_q <= shift_carry_d;
          res_valid_q <= 1'b1;
          state_q     <= SEQ_DONE;
        end
        SEQ_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= SEQ_IDLE;
          end
        end
        default: begin
          state_q     <= SEQ_IDLE;
          req_ready_q <= 1'b1;
          res_valid_q <= 1'b0;
          rf_raddr_q  <= 4'd0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign rf_raddr  = rf_raddr_q;

`ifdef ARM7TDMI_SHIFT_SEQ_PERF_EN
  logic [15:0] perf_ops_q;
  logic [15:0] perf_reg_ops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_q     <= 16'd0;
      perf_reg_ops_q <= 16'd0;
    end else if (res_valid_q && res_ready) begin
      if (perf_ops_q != 16'hFFFF) perf_ops_q <= perf_ops_q + 16'd1;
      if (shift_reg_q && perf_reg_ops_q != 16'hFFFF) perf_reg_ops_q <= perf_reg_ops_q + 16'd1;
    end
  end

  assign perf_ops     = perf_ops_q;
  assign perf_reg_ops = perf_reg_ops_q;
`endif

endmodule

// File: tb/tb_arm7tdmi_shift_seq.sv
// Directed-vector bench for arm7tdmi_shift_seq with a small register-file model.
module tb_arm7tdmi_shift_seq;
  import arm7tdmi_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  shift_type_t  req_type = SHIFT_LSL;
  logic [4:0]   req_amount = 5'd0;
  logic         req_shift_reg = 1'b0;
  logic [3:0]   req_rm = 4'd0;
  logic [3:0]   req_rs = 4'd0;
  logic         carry_in = 1'b0;
  logic [31:0]  pc_in = 32'd0;
  logic [3:0]   rf_raddr;
  logic [31:0]  rf_rdata;
  logic         flush = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [31:0]  res_data;
  logic         res_carry;
`ifdef ARM7TDMI_SHIFT_SEQ_PERF_EN
  logic [15:0]  perf_ops;
  logic [15:0]  perf_reg_ops;
`endif

  logic [31:0] regs [16];
  assign rf_rdata = regs[rf_raddr];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arm7tdmi_shift_seq dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_type      (req_type),
    .req_amount    (req_amount),
    .req_shift_reg (req_shift_reg),
    .req_rm        (req_rm),
    .req_rs        (req_rs),
    .carry_in      (carry_in),
    .pc_in         (pc_in),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .flush         (flush),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_carry     (res_carry)
`ifdef ARM7TDMI_SHIFT_SEQ_PERF_EN
    ,
    .perf_ops      (perf_ops),
    .perf_reg_ops  (perf_reg_ops)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input shift_type_t t, input logic [4:0] amt, input logic sr,
                       input logic [3:0] rm, input logic [3:0] rs, input logic c,
                       input logic [31:0] pc);
    req_type      = t;
    req_amount    = amt;
    req_shift_reg = sr;
    req_rm        = rm;
    req_rs        = rs;
    carry_in      = c;
    pc_in         = pc;
    req_valid     = 1'b1;
  endtask

  task automatic run_op(input string tag, input shift_type_t t, input logic [4:0] amt,
                        input logic sr, input logic [3:0] rm, input logic [3:0] rs,
                        input logic c, input logic [31:0] pc, input logic [31:0] exp_d,
                        input logic exp_c, input int exp_lat);
    int lat;
    drive(t, amt, sr, rm, rs, c, pc);
    tick();
    req_valid = 1'b0;
    chk({tag, ".raddr"}, 32'(rf_raddr), 32'(rm));
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".data"}, res_data, exp_d);
    chk({tag, ".carry"}, 32'(res_carry), 32'(exp_c));
    $display("op %s: data=%h c=%0d lat=%0d", tag, res_data, res_carry, lat);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, ".idle"}, {30'd0, req_ready, res_valid}, 32'h2);
  endtask

  initial begin
    logic [31:0] held;
    int          seen;
`ifdef ARM7TDMI_SHIFT_SEQ_PERF_EN
    logic [15:0] ops_before;
`endif
    for (int i = 0; i < 16; i++) regs[i] = 32'hDEAD0000 | 32'(i);
    regs[1] = 32'h80000001;
    regs[2] = 32'h00000000;
    regs[3] = 32'h00000003;
    regs[4] = 32'h80000018;
    regs[5] = 32'h00000001;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.valid", 32'(res_valid), 32'd0);
    chk("rst.data", res_data, 32'd0);
    chk("rst.carry", 32'(res_carry), 32'd0);
    chk("rst.raddr", 32'(rf_raddr), 32'd0);
    rst = 1'b0;
    tick();

    run_op("lsl4_imm", SHIFT_LSL, 5'd4, 1'b0, 4'd1, 4'd0, 1'b1, 32'h0, 32'h00000010, 1'b0, 2);
    regs[2] = 32'h20;
    run_op("lsr_r32", SHIFT_LSR, 5'd0, 1'b1, 4'd1, 4'd2, 1'b0, 32'h0, 32'h0, 1'b1, 3);
    regs[2] = 32'h21;
    run_op("lsr_r33", SHIFT_LSR, 5'd0, 1'b1, 4'd1, 4'd2, 1'b1, 32'h0, 32'h0, 1'b0, 3);
    regs[2] = 32'h100;
    run_op("lsr_r256", SHIFT_LSR, 5'd0, 1'b1, 4'd1, 4'd2, 1'b1, 32'h0, 32'h80000001, 1'b1, 3);
    regs[2] = 32'h20;
    run_op("ror_r32", SHIFT_ROR, 5'd0, 1'b1, 4'd1, 4'd2, 1'b0, 32'h0, 32'h80000001, 1'b1, 3);
    regs[2] = 32'h24;
    run_op("ror_r36", SHIFT_ROR, 5'd0, 1'b1, 4'd1, 4'd2, 1'b1, 32'h0, 32'h18000000, 1'b0, 3);
    regs[2] = 32'h40;
    run_op("asr_r64", SHIFT_ASR, 5'd0, 1'b1, 4'd1, 4'd2, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 3);
    regs[2] = 32'h20;
    run_op("lsl_r32", SHIFT_LSL, 5'd0, 1'b1, 4'd1, 4'd2, 1'b0, 32'h0, 32'h0, 1'b1, 3);
    regs[2] = 32'h21;
    run_op("lsl_r33", SHIFT_LSL, 5'd0, 1'b1, 4'd1, 4'd2, 1'b1, 32'h0, 32'h0, 1'b0, 3);
    regs[2] = 32'h04;
    run_op("lsr_r4", SHIFT_LSR, 5'd0, 1'b1, 4'd4, 4'd2, 1'b0, 32'h0, 32'h08000001, 1'b1, 3);
    regs[2] = 32'h0;
    run_op("pc_rm_reg", SHIFT_LSL, 5'd0, 1'b1, 4'd15, 4'd2, 1'b0, 32'h100, 32'h0000010C, 1'b0, 3);
    run_op("pc_rm_imm", SHIFT_LSL, 5'd0, 1'b0, 4'd15, 4'd0, 1'b0, 32'h100, 32'h00000108, 1'b0, 2);
    run_op("pc_rs", SHIFT_LSL, 5'd0, 1'b1, 4'd5, 4'd15, 1'b0, 32'h100, 32'h00001000, 1'b0, 3);
    run_op("lsr0_imm", SHIFT_LSR, 5'd0, 1'b0, 4'd1, 4'd0, 1'b0, 32'h0, 32'h0, 1'b1, 2);
    run_op("asr0_imm", SHIFT_ASR, 5'd0, 1'b0, 4'd1, 4'd0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 2);
    run_op("asr4_imm", SHIFT_ASR, 5'd4, 1'b0, 4'd1, 4'd0, 1'b0, 32'h0, 32'hF8000000, 1'b0, 2);
    run_op("rrx_imm", SHIFT_ROR, 5'd0, 1'b0, 4'd1, 4'd0, 1'b1, 32'h0, 32'hC0000000, 1'b1, 2);

    // flush while reading Rs
    regs[2] = 32'h4;
    drive(SHIFT_LSL, 5'd0, 1'b1, 4'd1, 4'd2, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("flush.rs_addr", 32'(rf_raddr), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.ready", 32'(req_ready), 32'd1);
    chk("flush.raddr", 32'(rf_raddr), 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid) seen++;
      tick();
    end
    chk("flush.no_valid", 32'(seen), 32'd0);
    $display("op flush_rs: valid_seen=%0d", seen);

    // flush beats a same-cycle accept in IDLE
    drive(SHIFT_LSL, 5'd1, 1'b0, 4'd3, 4'd0, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush.prio_ready", 32'(req_ready), 32'd1);
    chk("flush.prio_raddr", 32'(rf_raddr), 32'd0);
    $display("op flush_prio: ready=%0d", req_ready);

    // asynchronous reset in SHIFT; res_data currently holds a nonzero old result
    drive(SHIFT_LSL, 5'd1, 1'b0, 4'd3, 4'd0, 1'b1, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    chk("rst_mid.ready", 32'(req_ready), 32'd1);
    chk("rst_mid.valid", 32'(res_valid), 32'd0);
    chk("rst_mid.data", res_data, 32'd0);
    chk("rst_mid.carry", 32'(res_carry), 32'd0);
    chk("rst_mid.raddr", 32'(rf_raddr), 32'd0);
    $display("op rst_in_shift: data=%h ready=%0d", res_data, req_ready);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_mid.dropped", 32'(res_valid), 32'd0);

    // backpressure: result holds and no new request is taken
`ifdef ARM7TDMI_SHIFT_SEQ_PERF_EN
    ops_before = perf_ops;
`endif
    drive(SHIFT_LSL, 5'd1, 1'b0, 4'd3, 4'd0, 1'b0, 32'h0);
    tick();
    drive(SHIFT_ROR, 5'd8, 1'b0, 4'd1, 4'd0, 1'b0, 32'h0);
    seen = 0;
    while (!res_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("bp.lat", 32'(seen), 32'd2);
    held = res_data;
    chk("bp.data0", held, 32'h00000006);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.stable", res_data, 32'h00000006);
      chk("bp.valid_ready", {30'd0, res_valid, req_ready}, 32'h2);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp.done", {30'd0, req_ready, res_valid}, 32'h2);
    tick();
    chk("bp.no_accept", 32'(req_ready), 32'd1);
`ifdef ARM7TDMI_SHIFT_SEQ_PERF_EN
    chk("bp.perf_ops", 32'(perf_ops), 32'(ops_before + 16'd1));
`endif
    $display("op backpressure: data=%h", held);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
